// File: rtl/spi_flash_xfer_if.sv
// Parser-side bus of the SPI flash transfer engine: transaction request/status
// plus the write-byte and read-byte valid/ready streams.
interface spi_flash_xfer_if #(
    parameter int LEN_WIDTH = 16
) ();
    logic                 start_i;
    logic [LEN_WIDTH-1:0] wr_len_i;
    logic [LEN_WIDTH-1:0] rd_len_i;
    logic                 busy_o;
    logic                 done_o;
    logic [7:0]           wr_data_i;
    logic                 wr_valid_i;
    logic                 wr_ready_o;
    logic [7:0]           rd_data_o;
    logic                 rd_valid_o;
    logic                 rd_ready_i;

    modport master (
        output start_i, wr_len_i, rd_len_i, wr_data_i, wr_valid_i, rd_ready_i,
        input  busy_o, done_o, wr_ready_o, rd_data_o, rd_valid_o
    );

    modport slave (
        input  start_i, wr_len_i, rd_len_i, wr_data_i, wr_valid_i, rd_ready_i,
        output busy_o, done_o, wr_ready_o, rd_data_o, rd_valid_o
    );
endinterface

// File: rtl/spi_flash_xfer.sv
// SPI mode-0 master: streams wr_len bytes out MSB-first, then clocks in rd_len
// bytes, all within one chip-select assertion, followed by a CS-high gap.
module spi_flash_xfer #(
    parameter int SCK_DIV   = 2,
    parameter int LEN_WIDTH = 16,
    parameter int CS_IDLE   = 4
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    spi_flash_xfer_if.slave bus,
    output logic           sck_o,
    output logic           csn_o,
    output logic           mosi_o,
    input  logic           miso_i
);
    typedef enum logic [2:0] {
        IDLE, WR_FETCH, WR_SHIFT, RD_SHIFT, RD_HOLD, CS_END, GAP
    } state_t;

    localparam int TMAX = (SCK_DIV > CS_IDLE) ? SCK_DIV : CS_IDLE;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0]        HALF_LAST = TW'(SCK_DIV - 1);
    localparam logic [TW-1:0]        GAP_LAST  = TW'(CS_IDLE - 1);
    localparam logic [LEN_WIDTH-1:0] ONE       = LEN_WIDTH'(1);

    state_t               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           sreg_q, sreg_d;
    logic [LEN_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [LEN_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 sck_q, sck_d;
    logic                 csn_q, csn_d;
    logic                 mosi_q, mosi_d;

    logic half_end;
    logic byte_end;
    logic lens_zero;

    assign half_end  = (tmr_q == HALF_LAST);
    // The 8th falling edge: end of a high phase on the last bit.
    assign byte_end  = half_end && sck_q && (bit_q == 3'd7);
    assign lens_zero = (bus.wr_len_i == '0) && (bus.rd_len_i == '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            bit_q      <= '0;
            sreg_q     <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            sck_q      <= 1'b0;
            csn_q      <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            bit_q      <= bit_d;
            sreg_q     <= sreg_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            sck_q      <= sck_d;
            csn_q      <= csn_d;
            mosi_q     <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (lens_zero)                 state_d = GAP;
                    else if (bus.wr_len_i != '0)   state_d = WR_FETCH;
                    else                           state_d = RD_SHIFT;
                end
            end
            WR_FETCH: if (bus.wr_valid_i) state_d = WR_SHIFT;
            WR_SHIFT: begin
                if (byte_end) begin
                    if (wr_cnt_q != ONE)     state_d = WR_FETCH;
                    else if (rd_cnt_q != '0) state_d = RD_SHIFT;
                    else                     state_d = CS_END;
                end
            end
            RD_SHIFT: if (byte_end) state_d = RD_HOLD;
            RD_HOLD: begin
                if (bus.rd_ready_i) state_d = (rd_cnt_q != ONE) ? RD_SHIFT : CS_END;
            end
            CS_END: if (half_end) state_d = GAP;
            GAP:    if (tmr_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tmr_d      = '0;
        bit_d      = bit_q;
        sreg_d     = sreg_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        sck_d      = sck_q;
        csn_d      = csn_q;
        mosi_d     = mosi_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    wr_cnt_d = bus.wr_len_i;
                    rd_cnt_d = bus.rd_len_i;
                    busy_d   = 1'b1;
                    bit_d    = '0;
                    csn_d    = lens_zero;
                end
            end
            WR_FETCH: begin
                if (bus.wr_valid_i) begin
                    sreg_d = bus.wr_data_i;
                    mosi_d = bus.wr_data_i[7];
                    bit_d  = '0;
                end
            end
            WR_SHIFT: begin
                tmr_d = half_end ? '0 : tmr_q + 1'b1;
                if (half_end) begin
                    sck_d = ~sck_q;
                    // mosi only moves on the falling edge, so it is stable at every rise.
                    if (sck_q) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            wr_cnt_d = wr_cnt_q - ONE;
                            if (wr_cnt_q == ONE) mosi_d = 1'b0;
                        end else begin
                            mosi_d = sreg_q[6];
                            sreg_d = {sreg_q[6:0], 1'b0};
                        end
                    end
                end
            end
            RD_SHIFT: begin
                tmr_d = half_end ? '0 : tmr_q + 1'b1;
                if (half_end) begin
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        sreg_d = {sreg_q[6:0], miso_i};
                    end else begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            rd_data_d  = sreg_q;
                            rd_valid_d = 1'b1;
                        end
                    end
                end
            end
            RD_HOLD: begin
                if (bus.rd_ready_i) begin
                    rd_valid_d = 1'b0;
                    rd_cnt_d   = rd_cnt_q - ONE;
                    bit_d      = '0;
                end
            end
            CS_END: begin
                tmr_d = half_end ? '0 : tmr_q + 1'b1;
                if (half_end) csn_d = 1'b1;
            end
            GAP: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == GAP_LAST) begin
                    tmr_d  = '0;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: begin
                tmr_d = '0;
            end
        endcase
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.wr_ready_o = (state_q == WR_FETCH);
    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_valid_o = rd_valid_q;
    assign sck_o          = sck_q;
    assign csn_o          = csn_q;
    assign mosi_o         = mosi_q;
endmodule

// File: tb/tb_spi_flash_xfer.sv
// Bench for spi_flash_xfer with a small AT25SF081-style flash model (JEDEC ID
// and 0x03 read) and a queue scoreboard for returned read bytes.
module tb_spi_flash_xfer;
    localparam int SCK_DIV = 2;
    localparam int CS_IDLE = 4;

    logic clk = 1'b0;
    logic rstn;
    logic sck, csn, mosi;
    logic miso = 1'b0;

    spi_flash_xfer_if #(.LEN_WIDTH(16)) bus ();

    spi_flash_xfer #(.SCK_DIV(SCK_DIV), .LEN_WIDTH(16), .CS_IDLE(CS_IDLE)) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus),
        .sck_o (sck),
        .csn_o (csn),
        .mosi_o(mosi),
        .miso_i(miso)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] wdat[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    // Bus monitors; never cleared, tests work on deltas.
    int          sck_pulses  = 0;
    int          sck_cs_high = 0;
    int          cs_falls    = 0;
    int          cs_edge_bad = 0;
    int          done_cnt    = 0;
    logic [31:0] mosi_bits   = '0;

    always @(posedge sck) begin
        sck_pulses++;
        mosi_bits = {mosi_bits[30:0], mosi};
        if (csn !== 1'b0) sck_cs_high++;
    end

    always @(csn) begin
        if (csn === 1'b0) cs_falls++;
        if (sck === 1'b1 && rstn === 1'b1) cs_edge_bad++;
    end

    always @(posedge clk) if (bus.done_o === 1'b1) done_cnt++;

    // Flash image: deterministic byte per address.
    function automatic logic [7:0] img(input logic [23:0] a);
        logic [7:0] t;
        t = a[7:0] * 8'd3;
        return t ^ a[15:8] ^ 8'hC3;
    endfunction

    logic [7:0] fl_rx [4];
    logic [7:0] fl_sh    = '0;
    logic [7:0] fl_b     = '0;
    logic [2:0] fl_bit   = '0;
    int         fl_nb    = 0;
    logic       sck_prev = 1'b0;
    logic       csn_prev = 1'b1;

    function automatic logic [7:0] resp(input int idx);
        logic [23:0] a;
        if (fl_rx[0] == 8'h9F) begin
            if (idx == 1) return 8'h1F;
            if (idx == 2) return 8'h85;
            if (idx == 3) return 8'h01;
        end else if (fl_rx[0] == 8'h03 && idx >= 4) begin
            a = {fl_rx[1], fl_rx[2], fl_rx[3]} + 24'(idx - 4);
            return img(a);
        end
        return 8'h00;
    endfunction

    always @(sck or csn) begin
        if (csn_prev === 1'b1 && csn === 1'b0) begin
            fl_nb = 0;
            miso  = 1'b0;
        end else if (csn === 1'b0 && sck === 1'b1 && sck_prev === 1'b0) begin
            fl_sh = {fl_sh[6:0], mosi};
            if (fl_nb % 8 == 7 && fl_nb < 32) fl_rx[2'(fl_nb / 8)] = fl_sh;
            fl_nb++;
        end else if (csn === 1'b0 && sck === 1'b0 && sck_prev === 1'b1) begin
            fl_b   = resp(fl_nb / 8);
            fl_bit = 3'(7 - (fl_nb % 8));
            miso   = fl_b[fl_bit];
        end
        sck_prev = sck;
        csn_prev = csn;
    end

    logic rst_csn, rst_sck;

    // Runs one transaction from the parser side; read bytes land in got_q.
    task automatic do_xfer(input int wl, input int rl, input int wstall, input int rstall,
                           input int abort_at, output int lat, output bit timeout,
                           output int stall_cyc, output int stall_bad);
        int wi, ws, rs, n, sp0;
        bit fin;
        wi = 0; ws = 0; rs = 0; n = 0; fin = 0;
        timeout = 0; stall_cyc = 0; stall_bad = 0;
        sp0 = sck_pulses;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.wr_len_i = 16'(wl);
        bus.rd_len_i = 16'(rl);
        @(negedge clk);
        bus.start_i = 1'b0;
        n = 1;
        while (!fin) begin
            if (bus.done_o === 1'b1) begin
                fin = 1;
            end else if (n >= 20000) begin
                timeout = 1;
                fin = 1;
            end else if (abort_at > 0 && (sck_pulses - sp0) >= abort_at && sck === 1'b1) begin
                rstn = 1'b0;
                #1;
                rst_csn = csn;
                rst_sck = sck;
                bus.wr_valid_i = 1'b0;
                bus.rd_ready_i = 1'b0;
                fin = 1;
            end else begin
                if (bus.wr_ready_o === 1'b1 && wi < wl) begin
                    if (wi > 0 && ws < wstall) begin
                        ws++;
                        bus.wr_valid_i = 1'b0;
                        stall_cyc++;
                        if (sck !== 1'b0 || csn !== 1'b0) stall_bad++;
                    end else begin
                        bus.wr_valid_i = 1'b1;
                        bus.wr_data_i  = wdat[wi];
                        wi++;
                        ws = 0;
                    end
                end else begin
                    bus.wr_valid_i = 1'b0;
                end
                if (bus.rd_valid_o === 1'b1) begin
                    if (rs < rstall) begin
                        rs++;
                        bus.rd_ready_i = 1'b0;
                        stall_cyc++;
                        if (sck !== 1'b0 || csn !== 1'b0) stall_bad++;
                    end else begin
                        bus.rd_ready_i = 1'b1;
                        got_q.push_back(bus.rd_data_o);
                        rs = 0;
                    end
                end else begin
                    bus.rd_ready_i = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        bus.wr_valid_i = 1'b0;
        bus.rd_ready_i = 1'b0;
        lat = n;
        @(negedge clk);
        $display("xfer wr=%0d rd=%0d latency=%0d got=%0d timeout=%0d", wl, rl, lat, got_q.size(), timeout);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.busy_o, bus.done_o, bus.wr_ready_o, bus.rd_valid_o, sck, csn, mosi} !== 7'b0000010) begin
            n_bad++;
            $display("FAIL reset_ctrl_in_reset got=%b want=0000010",
                     {bus.busy_o, bus.done_o, bus.wr_ready_o, bus.rd_valid_o, sck, csn, mosi});
        end
        rstn = 1'b1;
        @(negedge clk);
        n_total++;
        if ({bus.busy_o, bus.done_o, bus.wr_ready_o, bus.rd_valid_o, sck, csn, mosi} !== 7'b0000010) begin
            n_bad++;
            $display("FAIL reset_ctrl_after got=%b want=0000010",
                     {bus.busy_o, bus.done_o, bus.wr_ready_o, bus.rd_valid_o, sck, csn, mosi});
        end
        n_total++;
        if (bus.rd_data_o !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rd_data got=%h want=00", bus.rd_data_o);
        end
    endtask

    task automatic test_wake();
        int sp0, cf0, dn0, ch0, eb0, lat, sc, sb;
        bit to;
        sp0 = sck_pulses; cf0 = cs_falls; dn0 = done_cnt; ch0 = sck_cs_high; eb0 = cs_edge_bad;
        wdat = '{8'hAB};
        got_q.delete();
        do_xfer(1, 0, 0, 0, 0, lat, to, sc, sb);
        n_total++;
        if (to) begin n_bad++; $display("FAIL wake_timeout got=timeout want=done"); end
        n_total++;
        if (sck_pulses - sp0 != 8) begin
            n_bad++; $display("FAIL wake_sck_pulses got=%0d want=8", sck_pulses - sp0);
        end
        n_total++;
        if (mosi_bits[7:0] !== 8'hAB) begin
            n_bad++; $display("FAIL wake_mosi got=%b want=10101011", mosi_bits[7:0]);
        end
        n_total++;
        if (cs_falls - cf0 != 1 || csn !== 1'b1) begin
            n_bad++; $display("FAIL wake_csn got_falls=%0d csn=%b want=1,1", cs_falls - cf0, csn);
        end
        n_total++;
        if (done_cnt - dn0 != 1) begin
            n_bad++; $display("FAIL wake_done got=%0d want=1", done_cnt - dn0);
        end
        n_total++;
        if (sck_cs_high != ch0 || cs_edge_bad != eb0) begin
            n_bad++; $display("FAIL wake_sck_vs_csn got=%0d/%0d want=0/0", sck_cs_high - ch0, cs_edge_bad - eb0);
        end
        n_total++;
        if (got_q.size() != 0) begin
            n_bad++; $display("FAIL wake_no_reads got=%0d want=0", got_q.size());
        end
    endtask

    task automatic test_read_id(input string tag);
        int lat, sc, sb;
        bit to;
        logic [7:0] e, g;
        wdat = '{8'h9F};
        exp_q.delete(); got_q.delete();
        exp_q.push_back(8'h1F); exp_q.push_back(8'h85); exp_q.push_back(8'h01);
        do_xfer(1, 3, 0, 0, 0, lat, to, sc, sb);
        n_total++;
        if (to) begin n_bad++; $display("FAIL %s_timeout got=timeout want=done", tag); end
        n_total++;
        if (got_q.size() != 3) begin
            n_bad++; $display("FAIL %s_count got=%0d want=3", tag, got_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_total++;
            if (g !== e) begin n_bad++; $display("FAIL %s_byte got=%h want=%h", tag, g, e); end
        end
    endtask

    task automatic test_read(input string tag, input int wstall, input int rstall);
        int lat, sc, sb, ch0, eb0;
        bit to;
        logic [7:0] e, g;
        wdat = '{8'h03, 8'h00, 8'h03, 8'hE8};
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(img(24'd1000 + 24'(i)));
        ch0 = sck_cs_high; eb0 = cs_edge_bad;
        do_xfer(4, 8, wstall, rstall, 0, lat, to, sc, sb);
        n_total++;
        if (to) begin n_bad++; $display("FAIL %s_timeout got=timeout want=done", tag); end
        n_total++;
        if (got_q.size() != 8) begin
            n_bad++; $display("FAIL %s_count got=%0d want=8", tag, got_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_total++;
            if (g !== e) begin n_bad++; $display("FAIL %s_byte got=%h want=%h", tag, g, e); end
        end
        n_total++;
        if (sck_cs_high != ch0 || cs_edge_bad != eb0) begin
            n_bad++; $display("FAIL %s_sck_vs_csn got=%0d/%0d want=0/0", tag, sck_cs_high - ch0, cs_edge_bad - eb0);
        end
        if (wstall > 0) begin
            n_total++;
            if (sc != 3 * wstall + 8 * rstall) begin
                n_bad++; $display("FAIL %s_stall_cycles got=%0d want=%0d", tag, sc, 3 * wstall + 8 * rstall);
            end
            n_total++;
            if (sb != 0) begin
                n_bad++; $display("FAIL %s_stall_lines got=%0d want=0", tag, sb);
            end
        end
    endtask

    task automatic test_nop();
        int sp0, cf0, dn0, lat, sc, sb;
        bit to;
        sp0 = sck_pulses; cf0 = cs_falls; dn0 = done_cnt;
        got_q.delete();
        do_xfer(0, 0, 0, 0, 0, lat, to, sc, sb);
        n_total++;
        if (to) begin n_bad++; $display("FAIL nop_timeout got=timeout want=done"); end
        n_total++;
        if (sck_pulses != sp0 || cs_falls != cf0) begin
            n_bad++; $display("FAIL nop_spi_activity got=%0d/%0d want=0/0", sck_pulses - sp0, cs_falls - cf0);
        end
        n_total++;
        if (lat < CS_IDLE || lat > CS_IDLE + 3) begin
            n_bad++; $display("FAIL nop_latency got=%0d want=%0d..%0d", lat, CS_IDLE, CS_IDLE + 3);
        end
        n_total++;
        if (done_cnt - dn0 != 1) begin
            n_bad++; $display("FAIL nop_done got=%0d want=1", done_cnt - dn0);
        end
    endtask

    task automatic test_reset_mid();
        int lat, sc, sb;
        bit to;
        wdat = '{8'h03, 8'h00, 8'h03, 8'hE8};
        got_q.delete();
        do_xfer(4, 8, 0, 0, 13, lat, to, sc, sb);
        n_total++;
        if (rst_csn !== 1'b1 || rst_sck !== 1'b0) begin
            n_bad++; $display("FAIL midrst_pins got=csn%b/sck%b want=csn1/sck0", rst_csn, rst_sck);
        end
        repeat (2) @(negedge clk);
        n_total++;
        if (bus.busy_o !== 1'b0 || bus.rd_valid_o !== 1'b0 || bus.wr_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL midrst_status got=%b%b%b want=000", bus.busy_o, bus.rd_valid_o, bus.wr_ready_o);
        end
        rstn = 1'b1;
        @(negedge clk);
        test_read_id("midrst_readid");
    endtask

    initial begin
        rstn           = 1'b0;
        bus.start_i    = 1'b0;
        bus.wr_len_i   = '0;
        bus.rd_len_i   = '0;
        bus.wr_data_i  = '0;
        bus.wr_valid_i = 1'b0;
        bus.rd_ready_i = 1'b0;
        test_reset();
        test_wake();
        test_read_id("readid");
        test_read("read", 0, 0);
        test_nop();
        test_read("stall", 50, 50);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
